// File: rtl/line_word_fifo.sv
// line_word_fifo: circular queue of DEPTH lines, each WORDS x WORD_W bits.
// A producer pushes one whole line per cycle. A consumer drains the head line
// either one word at a time (rd_valid/rd_ready) or discards it in one cycle (line_pop).
// Optional build macro LWF_ERR_FLAGS_EN adds sticky overflow/underflow flags
// (ovf_err, udf_err) and their clear input (err_clr).
module line_word_fifo #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int WIW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WORDS*WORD_W-1:0]  wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [AW:0]              count,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     rd_last,
    output logic [WIW-1:0]           rd_widx,
    output logic [WORDS*WORD_W-1:0]  line_data,
`ifdef LWF_ERR_FLAGS_EN
    input  logic                     err_clr,
    output logic                     ovf_err,
    output logic                     udf_err,
`endif
    input  logic                     line_pop
);

    localparam int LW = WORDS * WORD_W;

    logic [LW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          beat;
    logic          retire;

    // Occupancy flags come from the count alone so a full queue is never
    // mistaken for an empty one when the pointers coincide.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign rd_last  = (rd_widx == WIW'(WORDS - 1));

    // Push is judged against full as it stands at the start of the cycle,
    // so a retire in the same cycle never makes room for a rejected push.
    assign push   = wr_en && !full;
    assign beat   = rd_valid && rd_ready && !line_pop;
    assign retire = (line_pop && !empty) || (beat && rd_last);

    assign line_data = mem[rd_ptr];

    // Select the word of the head line currently being presented.
    always_comb begin
        rd_data = line_data[WORD_W-1:0];
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (rd_widx == WIW'(k)) begin
                rd_data = line_data[k*WORD_W +: WORD_W];
            end
        end
    end

    // Line storage: written on accepted pushes only, never cleared.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and word index within the head line.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_widx <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (retire) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_widx <= '0;
            end else if (beat) begin
                rd_widx <= rd_widx + WIW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(retire);
        end
    end

`ifdef LWF_ERR_FLAGS_EN
    logic ovf_new;
    logic udf_new;

    assign ovf_new = wr_en && full;
    assign udf_new = (rd_ready || line_pop) && empty;

    // Sticky error flags; a fresh error in the same cycle outranks err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (ovf_new) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (udf_new) begin
                udf_err <= 1'b1;
            end else if (err_clr) begin
                udf_err <= 1'b0;
            end
        end
    end
`endif

endmodule
